// File: rtl/dmem_if_rv32.sv
// Data-memory bus interface for the RV32I memory-access stage: one load/store
// request becomes one valid/ready bus transaction with alignment and extension.
module dmem_if_rv32 #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iReq,
  input  logic        iRW,
  input  logic [1:0]  iSize,
  input  logic        iUnsigned,
  input  logic [31:0] iAddr,
  input  logic [31:0] iWData,
  output logic        oStall,
  output logic [31:0] oRData,
  output logic        oMisalign,
  output logic        oBusErr,
  output logic        oMemValid,
  output logic        oMemWE,
  output logic [31:0] oMemAddr,
  output logic [3:0]  oMemBE,
  output logic [31:0] oMemWData,
  input  logic        iMemReady,
  input  logic [31:0] iMemRData
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] ofs);
    logic mis;
    case (size)
      2'b00:   mis = 1'b0;
      2'b01:   mis = ofs[0];
      2'b10:   mis = |ofs;
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

  function automatic logic [3:0] byteEnable(input logic [1:0] size, input logic [1:0] ofs);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << ofs;
      2'b01:   be = 4'b0011 << {ofs[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] storeData(input logic [1:0] size, input logic [31:0] d);
    logic [31:0] sd;
    case (size)
      2'b00:   sd = {4{d[7:0]}};
      2'b01:   sd = {2{d[15:0]}};
      default: sd = d;
    endcase
    return sd;
  endfunction

  // Word accesses are always aligned here, so the shifted word equals the raw word
  function automatic logic [31:0] loadFormat(input logic [1:0] size, input logic uns,
                                             input logic [1:0] ofs, input logic [31:0] rd);
    logic [31:0] sh;
    logic [31:0] res;
    sh = rd >> {ofs, 3'b000};
    case (size)
      2'b00:   res = {{24{~uns & sh[7]}}, sh[7:0]};
      2'b01:   res = {{16{~uns & sh[15]}}, sh[15:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

  state_t            state, stateNxt;
  logic [CNT_W-1:0]  cnt, cntNxt;
  logic [1:0]        ofsR, ofsNxt;
  logic [1:0]        sizeR, sizeNxt;
  logic              unsR, unsNxt;
  logic              rwR, rwNxt;
  logic [31:0]       rdataNxt;
  logic              misNxt, errNxt;
  logic              validNxt, weNxt;
  logic [31:0]       addrNxt;
  logic [3:0]        beNxt;
  logic [31:0]       wdataNxt;

  assign oStall = iReq & (state != DONE);

  // Next-state and next-output logic; every register holds unless a transition says otherwise
  always_comb begin
    stateNxt = state;
    cntNxt   = cnt;
    ofsNxt   = ofsR;
    sizeNxt  = sizeR;
    unsNxt   = unsR;
    rwNxt    = rwR;
    rdataNxt = oRData;
    misNxt   = 1'b0;
    errNxt   = 1'b0;
    validNxt = oMemValid;
    weNxt    = oMemWE;
    addrNxt  = oMemAddr;
    beNxt    = oMemBE;
    wdataNxt = oMemWData;
    case (state)
      IDLE: begin
        if (iReq) begin
          if (isMisaligned(iSize, iAddr[1:0])) begin
            stateNxt = DONE;
            misNxt   = 1'b1;
            rdataNxt = 32'd0;
          end else begin
            stateNxt = BUS;
            cntNxt   = '0;
            ofsNxt   = iAddr[1:0];
            sizeNxt  = iSize;
            unsNxt   = iUnsigned;
            rwNxt    = iRW;
            validNxt = 1'b1;
            weNxt    = ~iRW;
            addrNxt  = {iAddr[31:2], 2'b00};
            beNxt    = byteEnable(iSize, iAddr[1:0]);
            wdataNxt = storeData(iSize, iWData);
          end
        end else begin
          stateNxt = IDLE;
        end
      end
      BUS: begin
        // Ready wins over timeout when both land in the same cycle
        if (iMemReady) begin
          stateNxt = DONE;
          validNxt = 1'b0;
          weNxt    = 1'b0;
          if (rwR) begin
            rdataNxt = loadFormat(sizeR, unsR, ofsR, iMemRData);
          end else begin
            rdataNxt = oRData;
          end
        end else if ((TIMEOUT != 0) && (cnt == TO_LAST)) begin
          stateNxt = DONE;
          validNxt = 1'b0;
          weNxt    = 1'b0;
          errNxt   = 1'b1;
          rdataNxt = 32'd0;
        end else begin
          cntNxt = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      DONE: begin
        stateNxt = IDLE;
      end
      default: begin
        stateNxt = IDLE;
        validNxt = 1'b0;
        weNxt    = 1'b0;
      end
    endcase
  end

  // State, captured request fields and all registered outputs
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state     <= IDLE;
      cnt       <= '0;
      ofsR      <= 2'b00;
      sizeR     <= 2'b00;
      unsR      <= 1'b0;
      rwR       <= 1'b0;
      oRData    <= 32'd0;
      oMisalign <= 1'b0;
      oBusErr   <= 1'b0;
      oMemValid <= 1'b0;
      oMemWE    <= 1'b0;
      oMemAddr  <= 32'd0;
      oMemBE    <= 4'd0;
      oMemWData <= 32'd0;
    end else begin
      state     <= stateNxt;
      cnt       <= cntNxt;
      ofsR      <= ofsNxt;
      sizeR     <= sizeNxt;
      unsR      <= unsNxt;
      rwR       <= rwNxt;
      oRData    <= rdataNxt;
      oMisalign <= misNxt;
      oBusErr   <= errNxt;
      oMemValid <= validNxt;
      oMemWE    <= weNxt;
      oMemAddr  <= addrNxt;
      oMemBE    <= beNxt;
      oMemWData <= wdataNxt;
    end
  end

endmodule

// File: tb/tb_dmem_if_rv32.sv
// Scoreboard bench for dmem_if_rv32: stimulus pushes expected bus and response
// records, a negedge monitor pops and compares them.
module tb_dmem_if_rv32;
  localparam int TO = 5;

  logic        iCLK = 1'b0;
  logic        iRST, iReq, iRW, iUnsigned, iMemReady;
  logic [1:0]  iSize;
  logic [31:0] iAddr, iWData, iMemRData;
  logic        oStall, oMisalign, oBusErr, oMemValid, oMemWE;
  logic [31:0] oRData, oMemAddr, oMemWData;
  logic [3:0]  oMemBE;

  dmem_if_rv32 #(.TIMEOUT(TO), .CNT_W(3)) dut (
    .iCLK(iCLK), .iRST(iRST), .iReq(iReq), .iRW(iRW), .iSize(iSize),
    .iUnsigned(iUnsigned), .iAddr(iAddr), .iWData(iWData), .oStall(oStall),
    .oRData(oRData), .oMisalign(oMisalign), .oBusErr(oBusErr),
    .oMemValid(oMemValid), .oMemWE(oMemWE), .oMemAddr(oMemAddr),
    .oMemBE(oMemBE), .oMemWData(oMemWData), .iMemReady(iMemReady),
    .iMemRData(iMemRData)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    int          cycles;
  } bus_t;

  typedef struct {
    logic        mis;
    logic        err;
    logic [31:0] rdata;
    int          stalls;
    logic        usesBus;
  } resp_t;

  bus_t        busQ[$];
  resp_t       respQ[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] modelRData;

  int          validCnt = 0;
  int          stallCnt = 0;
  logic [31:0] heldRData = 32'd0;
  bus_t        mb;
  resp_t       mr;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Monitor: bus fields every valid cycle, full response in the completion cycle
  always @(negedge iCLK) begin
    if (iRST) begin
      validCnt  = 0;
      stallCnt  = 0;
      heldRData = 32'd0;
    end else begin
      if (oMemValid) begin
        validCnt++;
        if (busQ.size() == 0) begin
          chk1("bus_unexpected_valid", oMemValid, 1'b0);
        end else begin
          mb = busQ[0];
          chk32("mem_addr", oMemAddr, mb.addr);
          chk32("mem_be", {28'd0, oMemBE}, {28'd0, mb.be});
          chk1("mem_we", oMemWE, mb.we);
          if (mb.we) chk32("mem_wdata", oMemWData, mb.wdata);
        end
      end
      if (iReq && oStall) stallCnt++;
      if (iReq && !oStall) begin
        if (respQ.size() == 0) begin
          chk1("resp_unexpected_done", oStall, 1'b1);
        end else begin
          mr = respQ.pop_front();
          chk1("misalign", oMisalign, mr.mis);
          chk1("bus_err", oBusErr, mr.err);
          chk32("rdata", oRData, mr.rdata);
          chk32("stall_cycles", stallCnt, mr.stalls);
          if (mr.usesBus) begin
            if (busQ.size() == 0) begin
              chk1("bus_missing", 1'b0, 1'b1);
            end else begin
              mb = busQ.pop_front();
              chk32("valid_cycles", validCnt, mb.cycles);
            end
          end else begin
            chk32("valid_cycles_misaligned", validCnt, 32'd0);
          end
          heldRData = mr.rdata;
        end
        validCnt = 0;
        stallCnt = 0;
      end else if (!iReq) begin
        chk1("idle_misalign", oMisalign, 1'b0);
        chk1("idle_bus_err", oBusErr, 1'b0);
        chk1("idle_valid", oMemValid, 1'b0);
        chk32("idle_rdata_hold", oRData, heldRData);
      end
    end
  end

  task automatic finishRun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  // One request: build expectations from the access rules, then drive it to completion
  task automatic doTxn(input logic rw, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input int delay, input logic [31:0] rdata);
    int          ofs;
    bit          mis;
    bit          timedOut;
    resp_t       r;
    bus_t        b;
    logic [31:0] v;
    int          busIdx;
    int          guard;
    ofs = int'(addr % 32'd4);
    mis = (size == 2'd3) || (size == 2'd1 && (ofs % 2) == 1) || (size == 2'd2 && ofs != 0);
    r.mis = 1'b0; r.err = 1'b0; r.rdata = 32'd0; r.stalls = 1; r.usesBus = 1'b0;
    if (mis) begin
      r.mis = 1'b1;
    end else begin
      timedOut = (delay >= TO);
      b.addr   = addr - 32'(ofs);
      b.we     = ~rw;
      if (size == 2'd0) begin
        b.be    = 4'(1 << ofs);
        b.wdata = 32'(wdata[7:0]) * 32'h01010101;
      end else if (size == 2'd1) begin
        b.be    = 4'(3 << ofs);
        b.wdata = 32'(wdata[15:0]) * 32'h00010001;
      end else begin
        b.be    = 4'hF;
        b.wdata = wdata;
      end
      b.cycles  = timedOut ? TO : delay + 1;
      r.stalls  = b.cycles + 1;
      r.usesBus = 1'b1;
      if (timedOut) begin
        r.err = 1'b1;
      end else if (rw) begin
        v = rdata >> (8 * ofs);
        if (size == 2'd0) begin
          v = v % 32'd256;
          if (!uns && v >= 32'd128) v = v + 32'hFFFFFF00;
        end else if (size == 2'd1) begin
          v = v % 32'd65536;
          if (!uns && v >= 32'd32768) v = v + 32'hFFFF0000;
        end
        r.rdata = v;
      end else begin
        r.rdata = modelRData;
      end
      busQ.push_back(b);
    end
    modelRData = r.rdata;
    respQ.push_back(r);

    @(posedge iCLK); #1;
    iReq = 1'b1; iRW = rw; iSize = size; iUnsigned = uns; iAddr = addr; iWData = wdata;
    iMemReady = 1'b0;
    busIdx = 0;
    guard  = 0;
    while (guard < 60) begin
      @(negedge iCLK);
      guard++;
      if (!oStall) break;
      if (oMemValid) begin
        iMemReady = (busIdx == delay);
        iMemRData = (busIdx == delay) ? rdata : $urandom;
        busIdx++;
      end else begin
        iMemReady = 1'($urandom_range(0, 1));
        iMemRData = $urandom;
      end
    end
    if (guard >= 60) begin
      checks++;
      errors++;
      $display("FAIL txn_timeout: got no completion expected one within 60 cycles");
      finishRun();
    end
    @(posedge iCLK); #1;
    iReq = 1'b0;
    iMemReady = 1'b0;
    repeat ($urandom_range(0, 2)) @(posedge iCLK);
  endtask

  initial begin
    iRST = 1'b1; iReq = 1'b0; iRW = 1'b0; iSize = 2'd0; iUnsigned = 1'b0;
    iAddr = 32'd0; iWData = 32'd0; iMemReady = 1'b0; iMemRData = 32'd0;
    modelRData = 32'd0;
    repeat (3) @(posedge iCLK);
    #1;
    chk1("rst_valid", oMemValid, 1'b0);
    chk1("rst_we", oMemWE, 1'b0);
    chk1("rst_misalign", oMisalign, 1'b0);
    chk1("rst_bus_err", oBusErr, 1'b0);
    chk32("rst_rdata", oRData, 32'd0);
    chk32("rst_addr", oMemAddr, 32'd0);
    iReq = 1'b1; #1;
    chk1("rst_stall_follows_req", oStall, 1'b1);
    iReq = 1'b0; #1;
    chk1("rst_stall_idle", oStall, 1'b0);
    iRST = 1'b0;

    doTxn(1'b1, 2'd2, 1'b0, 32'h00000100, 32'd0, 0, 32'hDEADBEEF);
    doTxn(1'b1, 2'd0, 1'b0, 32'h00000103, 32'd0, 1, 32'h80FF0000);
    doTxn(1'b1, 2'd0, 1'b1, 32'h00000103, 32'd0, 2, 32'h80FF0000);
    doTxn(1'b0, 2'd1, 1'b0, 32'h00000202, 32'h1234ABCD, 4, 32'h0);
    doTxn(1'b1, 2'd2, 1'b0, 32'h00000101, 32'd0, 0, 32'h11111111);
    doTxn(1'b1, 2'd3, 1'b0, 32'h00000100, 32'd0, 0, 32'h22222222);
    doTxn(1'b1, 2'd1, 1'b0, 32'h00000402, 32'd0, 3, 32'h9ABC5678);
    doTxn(1'b1, 2'd2, 1'b0, 32'h00000300, 32'd0, 99, 32'h33333333);
    doTxn(1'b0, 2'd0, 1'b0, 32'h00000501, 32'hCAFEF00D, 0, 32'h0);

    // Reset asserted during the second bus cycle of a load
    mb.addr = 32'h00000040; mb.be = 4'hF; mb.we = 1'b0; mb.wdata = 32'd0; mb.cycles = 0;
    busQ.push_back(mb);
    @(posedge iCLK); #1;
    iReq = 1'b1; iRW = 1'b1; iSize = 2'd2; iUnsigned = 1'b0; iAddr = 32'h00000040;
    iMemReady = 1'b0;
    @(posedge iCLK); #1;
    @(posedge iCLK); #1;
    chk1("mid_rst_valid_before", oMemValid, 1'b1);
    iRST = 1'b1;
    @(posedge iCLK); #1;
    chk1("mid_rst_valid_after", oMemValid, 1'b0);
    chk1("mid_rst_misalign", oMisalign, 1'b0);
    chk1("mid_rst_bus_err", oBusErr, 1'b0);
    chk1("mid_rst_stall_idle", oStall, 1'b1);
    iRST = 1'b0; iReq = 1'b0;
    busQ.delete();
    respQ.delete();
    modelRData = 32'd0;
    @(posedge iCLK);

    for (int n = 0; n < 200; n++) begin
      doTxn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            $urandom, $urandom, int'($urandom_range(0, 6)), $urandom);
    end

    repeat (3) @(posedge iCLK);
    chk32("queues_drained", 32'(respQ.size() + busQ.size()), 32'd0);
    finishRun();
  end

  initial begin
    #500000;
    checks++;
    errors++;
    $display("FAIL global_time_limit: got still running expected finished");
    finishRun();
  end
endmodule
